// File: rtl/serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_pkg
//   Shared definitions for the bit-serial adder/subtractor.
//   - state_e   : FSM state encoding (IDLE, RUN, DONE)
//   - cnt_width : width of the bit counter, sized so it can hold WIDTH itself
// ---------------------------------------------------------------------------
package serial_addsub_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    // Counter must reach WIDTH without wrapping, hence WIDTH+1 codes.
    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/serial_addsub_if.sv
// ---------------------------------------------------------------------------
// serial_addsub_if
//   Request/result bundle for serial_addsub.
//   master (requester): drives start, sub, a, b; observes busy, done,
//                       result, c_out, overflow.
//   slave  (engine)   : the reverse.
// ---------------------------------------------------------------------------
interface serial_addsub_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             c_out;
    logic             overflow;

    modport master (
        output start, sub, a, b,
        input  busy, done, result, c_out, overflow
    );

    modport slave (
        input  start, sub, a, b,
        output busy, done, result, c_out, overflow
    );
endinterface

// File: rtl/serial_addsub_fa.sv
// ---------------------------------------------------------------------------
// FullAdder
//   Single-bit full adder cell used by the serial datapath.
//   a_i, b_i : operand bits
//   c_i      : carry in
//   s_o      : sum bit
//   co_o     : carry out
// ---------------------------------------------------------------------------
module FullAdder (
    input  logic a_i,
    input  logic b_i,
    input  logic c_i,
    output logic s_o,
    output logic co_o
);
    assign s_o  = a_i ^ b_i ^ c_i;
    assign co_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
//   Bit-serial two's complement adder/subtractor, one bit per clock, LSB
//   first, through a single full-adder cell.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : serial_addsub_if.slave
//           start/sub/a/b sampled in IDLE only; busy high in RUN and DONE;
//           done pulses for one cycle with result/c_out/overflow valid,
//           which then hold until the next accepted start.
//   Timing: start sampled at edge 0, WIDTH RUN cycles (edges 1..WIDTH),
//   DONE in the cycle ending at edge WIDTH+1, next start at edge WIDTH+2.
// ---------------------------------------------------------------------------
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    serial_addsub_if.slave bus
);
    localparam int                CNT_W = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q,   a_d;
    logic [WIDTH-1:0] b_q,   b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic             ovf_q,   ovf_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic             fa_s, fa_co;

    // The only arithmetic in the block: one bit per RUN cycle.
    FullAdder u_fa (
        .a_i  (a_q[0]),
        .b_i  (b_q[0]),
        .c_i  (carry_q),
        .s_o  (fa_s),
        .co_o (fa_co)
    );

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath control
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    // Subtraction is a + ~b + 1: invert B and seed carry with 1.
                    a_d     = bus.a;
                    b_d     = bus.b ^ {WIDTH{bus.sub}};
                    carry_d = bus.sub;
                    res_d   = '0;
                    ovf_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                // Sum enters at the MSB so after WIDTH shifts bit 0 sits at LSB.
                res_d   = {fa_s, res_q[WIDTH-1:1]};
                carry_d = fa_co;
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    // carry_q is the carry into the MSB on this cycle.
                    ovf_d   = carry_q ^ fa_co;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.result   = res_q;
    assign bus.c_out    = carry_q;
    assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub (WIDTH=8). Expected results are
//   pushed to a scoreboard queue when a request is driven and popped by a
//   monitor when done rises; the monitor also checks done latency.
// ---------------------------------------------------------------------------
module tb_serial_addsub;
    localparam int W = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    serial_addsub_if #(.WIDTH(W)) bus ();

    serial_addsub #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic [W-1:0] res;
        logic         c;
        logic         ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Independent reference: whole-word arithmetic.
    function automatic vec_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub);
        vec_t         v;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb    = b ^ {W{sub}};
        full  = {1'b0, a} + {1'b0, bb} + (W+1)'(sub);
        v.a   = a;
        v.b   = b;
        v.sub = sub;
        v.res = full[W-1:0];
        v.c   = full[W];
        v.ovf = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
        return v;
    endfunction

    // Monitor: each done pops one expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            n_done++;
            if (sbq.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL spurious_done: got done=1 expected no pending request (cycle %0d)", cyc);
            end else begin
                mon_e = sbq.pop_front();
                check("result",   bus.result,   mon_e.res);
                check("c_out",    bus.c_out,    mon_e.c);
                check("overflow", bus.overflow, mon_e.ovf);
                check("latency",  cyc - mon_e.cyc, W);
            end
        end
    end

    task automatic push_exp(input vec_t v);
        exp_t e;
        e.res = v.res;
        e.c   = v.c;
        e.ovf = v.ovf;
        e.cyc = cyc + 1;  // acceptance edge is the next rising edge
        sbq.push_back(e);
    endtask

    task automatic wait_drain(input string nm);
        int t = 0;
        while (sbq.size() != 0 && t < 4 * W) begin
            @(posedge clk);
            t++;
        end
        if (sbq.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, sbq.size());
            sbq.delete();
        end
    endtask

    // One operation; scramble changes operands and re-pulses start during RUN.
    task automatic run_op(input vec_t v, input bit scramble);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = v.a;
        bus.b     = v.b;
        bus.sub   = v.sub;
        push_exp(v);
        @(negedge clk);
        bus.start = 1'b0;
        check("busy_run", bus.busy, 1'b1);
        if (scramble) begin
            bus.a   = ~v.a;
            bus.b   = W'($urandom);
            bus.sub = ~v.sub;
            repeat (3) @(negedge clk);
            bus.start = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
        end
        wait_drain("op");
        @(negedge clk);
        check("hold_result", bus.result, v.res);
        check("hold_c_out",  bus.c_out,  v.c);
        check("idle_busy",   bus.busy,   1'b0);
    endtask

    vec_t tbl[8];
    vec_t bb[3];
    int   d0;

    initial begin
        bus.start = 1'b0;
        bus.sub   = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        tbl[0] = '{8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h03, 8'h05, 1'b1, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1};
        tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        tbl[6] = '{8'h00, 8'h80, 1'b1, 8'h80, 1'b0, 1'b1};
        tbl[7] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy",   bus.busy,     1'b0);
        check("rst_done",   bus.done,     1'b0);
        check("rst_result", bus.result,   '0);
        check("rst_c_out",  bus.c_out,    1'b0);
        check("rst_ovf",    bus.overflow, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_op(tbl[i], 1'b0);

        // Random operands against the word-level model, some with RUN-time noise
        for (int i = 0; i < 6; i++)
            run_op(model(W'($urandom), W'($urandom), 1'(i & 1)), 1'(i >= 3));

        // Back-to-back with start held high
        bb[0] = model(8'h12, 8'h34, 1'b0);
        bb[1] = model(8'h34, 8'h12, 1'b1);
        bb[2] = model(8'hC0, 8'h50, 1'b0);
        d0 = n_done;
        @(negedge clk);
        bus.start = 1'b1;
        for (int k = 0; k < 3; k++) begin
            bus.a   = bb[k].a;
            bus.b   = bb[k].b;
            bus.sub = bb[k].sub;
            push_exp(bb[k]);
            repeat (W + 2) @(negedge clk);
        end
        bus.start = 1'b0;
        wait_drain("b2b");
        repeat (3) @(negedge clk);
        check("b2b_done_count", n_done - d0, 3);

        // Reset mid-RUN
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 8'h5A;
        bus.b     = 8'h3C;
        bus.sub   = 1'b0;
        push_exp(model(8'h5A, 8'h3C, 1'b0));
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        sbq.delete();
        #1;
        check("abort_busy",   bus.busy,   1'b0);
        check("abort_result", bus.result, '0);
        check("abort_done",   bus.done,   1'b0);
        d0 = n_done;
        repeat (W + 4) @(negedge clk);
        check("abort_no_done", n_done - d0, 0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        #2;
        check("release_busy", bus.busy, 1'b0);
        run_op(model(8'hA5, 8'h5A, 1'b1), 1'b0);
        run_op(model(8'hFE, 8'h02, 1'b0), 1'b0);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
